interval_scheduler: RTL and testbench

Round-robin scheduler that shares one 4-bit interval counter among several requesters. Each requester asks for a timed interval of a given length in clock cycles. The scheduler grants one requester at a time, runs the shared counter for the requested length, and returns a one-cycle completion pulse to that requester. It sits between the requesting control blocks and the counter datapath, and it owns sequencing and fairness for the counter.

---
 rtl/interval_scheduler.sv | 103 ++++++++++
 tb/tb_interval_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/interval_scheduler.sv
// Round-robin owner of a shared interval counter: grants one requester at a time,
// counts its requested duration, then returns a one-cycle done pulse to it.
module interval_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   dur,
    input  logic                    abort,
    output logic [NREQ-1:0]         grant,
    output logic [WIDTH-1:0]        count,
    output logic                    busy,
    output logic [NREQ-1:0]         done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    last;
    logic [IW-1:0]    owner;
    logic [WIDTH-1:0] dur_q;

    logic [IW-1:0]    pick;
    logic [WIDTH-1:0] dur_pick;
    logic             found;
    int unsigned      idx;

    // Search starts one past the previous owner so the last winner goes to the back.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
        dur_pick = dur[int'(pick)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            last  <= IW'(NREQ - 1);
            owner <= '0;
            dur_q <= '0;
            grant <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= '0;
                    count <= '0;
                    if (found) begin
                        owner <= pick;
                        last  <= pick;
                        dur_q <= dur_pick;
                        grant <= NREQ'(1) << pick;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        grant <= '0;
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == dur_q - 1'b1) begin
                        // dur_q of 0 wraps to all-ones here, giving a full 2^WIDTH interval
                        grant <= '0;
                        done  <= NREQ'(1) << owner;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    count <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    done  <= '0;
                    count <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interval_scheduler.sv
// Bench for interval_scheduler: directed scenarios plus random traffic checked
// against a transaction-level model that expands each grant into its output timeline.
module tb_interval_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic              clock = 1'b0;
    logic              clear;
    logic [NREQ-1:0]   req;
    logic [NREQ*WIDTH-1:0] dur;
    logic              abort;
    logic [NREQ-1:0]   grant;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic [NREQ-1:0]   done;

    int n_checks = 0;
    int n_fail   = 0;

    interval_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .req   (req),
        .dur   (dur),
        .abort (abort),
        .grant (grant),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NREQ-1:0]  g;
        logic [WIDTH-1:0] c;
        logic             b;
        logic [NREQ-1:0]  d;
    } exp_t;

    exp_t q[$];
    int   m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = NREQ - 1;
    endtask

    // Whole interval is queued at grant time: len counting cycles, then one done cycle.
    task automatic model_edge();
        int len;
        int w;
        if (!clear) begin
            model_reset();
        end else if (q.size() > 0) begin
            if (abort && q[0].g != '0) q.delete();
            else void'(q.pop_front());
        end else if (req != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            len = int'(dur[w*WIDTH +: WIDTH]);
            if (len == 0) len = 1 << WIDTH;
            for (int n = 0; n < len; n++)
                q.push_back('{g: NREQ'(1) << w, c: WIDTH'(n), b: 1'b1, d: '0});
            q.push_back('{g: '0, c: WIDTH'(len - 1), b: 1'b1, d: NREQ'(1) << w});
            m_last = w;
        end
    endtask

    task automatic compare();
        exp_t e;
        e = '{g: '0, c: '0, b: 1'b0, d: '0};
        if (q.size() > 0) e = q[0];
        check("grant", 32'(grant), 32'(e.g));
        check("count", 32'(count), 32'(e.c));
        check("busy",  32'(busy),  32'(e.b));
        check("done",  32'(done),  32'(e.d));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        clear = 1'b0;
        #1;
        model_reset();
        compare();
        repeat (2) cycle();
        clear = 1'b1;
    endtask

    initial begin
        int order[$];
        int n;
        int b_cnt;
        int first;

        clear = 1'b0;
        req   = 4'($urandom);
        dur   = 16'($urandom);
        abort = 1'b0;
        model_reset();
        #1;
        compare();
        repeat (3) cycle();
        req = '0;
        clear = 1'b1;
        repeat (3) cycle();
        check("idle_busy", 32'(busy), 32'(0));

        // single request, requester 1 for 3 cycles
        req = 4'b0010;
        dur = 16'h0030;
        cycle();
        req = '0;
        b_cnt = busy ? 1 : 0;
        repeat (7) begin
            cycle();
            if (busy) b_cnt++;
        end
        check("single_busy_len", 32'(b_cnt), 32'(4));

        // round-robin order from fresh reset
        do_reset();
        req = 4'b1111;
        dur = 16'h1111;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (grant != '0 && order.size() < 5)
                for (int bb = 0; bb < NREQ; bb++) if (grant[bb]) order.push_back(bb);
        end
        for (int i = 0; i < 5; i++)
            check("rr_order", 32'(i < order.size() ? order[i] : 99), 32'(i % NREQ));
        req = '0;
        repeat (3) cycle();

        // full wrap on requester 2
        req = 4'b0100;
        dur = 16'h0000;
        cycle();
        req = '0;
        n = (grant == 4'b0100) ? 1 : 0;
        repeat (21) begin
            cycle();
            if (grant == 4'b0100) n++;
        end
        check("wrap_len", 32'(n), 32'(16));

        // abort requester 0 at count 3, requester 1 waiting
        do_reset();
        req = 4'b0011;
        dur = 16'h0028;
        cycle();
        req = 4'b0010;
        for (int i = 0; i < 20 && count != 4'd3; i++) cycle();
        check("abort_reach", 32'(count), 32'(3));
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_grant", 32'(grant), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        cycle();
        check("abort_next", 32'(grant), 32'(4'b0010));
        req = '0;
        repeat (5) cycle();

        // clear pulsed mid-count
        req = 4'b0001;
        dur = 16'h0008;
        for (int i = 0; i < 20 && count != 4'd5; i++) cycle();
        check("mid_reach", 32'(count), 32'(5));
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        compare();
        cycle();
        clear = 1'b1;
        req = 4'b1111;
        cycle();
        check("mid_first", 32'(grant), 32'(4'b0001));
        req = '0;
        for (int i = 0; i < 12; i++) cycle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            if ($urandom_range(3) == 0) begin
                dur = 16'($urandom);
                if ($urandom_range(1) == 0) dur = dur & 16'h3333;
            end
            abort = ($urandom_range(15) == 0);
            if ($urandom_range(199) == 0) begin
                clear = 1'b0;
                #1;
                model_reset();
                compare();
                #2;
                clear = 1'b1;
            end
            cycle();
        end
        abort = 1'b0;
        req = '0;

        first = n_checks;
        check("ran_random", 32'(first > 1000), 32'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
